// File: rtl/clk_cfg_sched.sv
// clk_cfg_sched: round-robin scheduler that turns per-requester prescaler
// reconfiguration requests into single 16-bit writes on the clock generator's
// register port, then holds a settle window before acknowledging.
// Optional readback check is compiled in with CLK_CFG_READBACK_EN.
module clk_cfg_sched #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_PRESCALER = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*3-1:0]    req_sel,
  input  logic [NUM_REQ*16-1:0]   req_value,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      err,
  output logic                    busy,
  output logic [31:0]             cfg_addr,
  output logic [3:0]              cfg_wmask,
  output logic [3:0]              cfg_rmask,
  output logic [31:0]             cfg_wdata,
  input  logic [31:0]             cfg_rdata
);

  localparam int PW = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, SETTLE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [2:0]    sel_q;
  logic [15:0]   val_q;
  logic [CW-1:0] cnt;
  logic          err_pending;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [2:0]    pick_sel;
  logic [15:0]   pick_val;
  logic [PW-1:0] ptr_next;

  // Read data is only inspected in the readback build, and only its low half.
  wire unused_rdata = ^cfg_rdata;

  assign busy = (state != IDLE);

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to ptr (offset 0) wins.
  always_comb begin : rr_pick
    logic [PW:0] s;
    pick_found = 1'b0;
    pick_idx   = '0;
    s          = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (PW+1)'(i);
      if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
      if (req[s[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = s[PW-1:0];
      end
    end
    pick_sel = req_sel[pick_idx*3 +: 3];
    pick_val = req_value[pick_idx*16 +: 16];
    ptr_next = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Main FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      sel_q       <= '0;
      val_q       <= '0;
      cnt         <= '0;
      err_pending <= 1'b0;
      ack         <= '0;
      err         <= '0;
      cfg_addr    <= '0;
      cfg_wmask   <= '0;
      cfg_rmask   <= '0;
      cfg_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt   <= pick_idx;
            sel_q <= pick_sel;
            val_q <= pick_val;
            ptr   <= ptr_next;
            if (int'(pick_sel) >= NUM_PRESCALER) begin
              // Unmapped prescaler index: fail without touching the bus.
              err_pending <= 1'b1;
              ack         <= NUM_REQ'(1) << pick_idx;
              err         <= NUM_REQ'(1) << pick_idx;
              state       <= DONE;
            end else begin
              err_pending <= 1'b0;
              cfg_addr    <= {27'd0, pick_sel, 2'b00};
              cfg_wmask   <= 4'b0011;
              cfg_wdata   <= {16'h0000, pick_val};
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          cfg_wmask <= '0;
          cfg_wdata <= '0;
`ifdef CLK_CFG_READBACK_EN
          cfg_rmask <= 4'b0011;
          state     <= READ;
`else
          cfg_addr  <= '0;
          cnt       <= CW'(SETTLE_CYCLES);
          state     <= SETTLE;
`endif
        end
`ifdef CLK_CFG_READBACK_EN
        READ: begin
          cfg_rmask <= '0;
          cfg_addr  <= '0;
          state     <= CHECK;
        end
        CHECK: begin
          // Slave returns registered data one cycle after the read strobe.
          err_pending <= err_pending | (cfg_rdata[15:0] != val_q);
          cnt         <= CW'(SETTLE_CYCLES);
          state       <= SETTLE;
        end
`endif
        SETTLE: begin
          if (cnt == '0) begin
            ack   <= NUM_REQ'(1) << gnt;
            err   <= err_pending ? (NUM_REQ'(1) << gnt) : '0;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ack         <= '0;
          err         <= '0;
          err_pending <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_cfg_sched.sv
// Directed self-checking bench for clk_cfg_sched (NUM_REQ=4, SETTLE_CYCLES=16).
// Expected latencies follow CLK_CFG_READBACK_EN when it is defined.
module tb_clk_cfg_sched;
  localparam int N = 4;
`ifdef CLK_CFG_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*3-1:0]  req_sel = '0;
  logic [N*16-1:0] req_value = '0;
  logic [N-1:0]    ack, err;
  logic            busy;
  logic [31:0]     cfg_addr, cfg_wdata;
  logic [31:0]     cfg_rdata = '0;
  logic [3:0]      cfg_wmask, cfg_rmask;

  clk_cfg_sched #(.NUM_REQ(N), .SETTLE_CYCLES(16), .NUM_PRESCALER(6)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_value(req_value),
    .ack(ack), .err(err), .busy(busy), .cfg_addr(cfg_addr), .cfg_wmask(cfg_wmask),
    .cfg_rmask(cfg_rmask), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc, wr_cnt, rd_cnt, ack_cnt, multi_ack, both_cnt, idle_gap, ack_cyc, wr_cyc, stray_err;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_mask;
  logic [N-1:0] ack_log[$];
  logic [N-1:0] err_log[$];
  logic [N-1:0] drop_mask = '1;

  task automatic clear_log();
    cyc = 0; wr_cnt = 0; rd_cnt = 0; ack_cnt = 0; multi_ack = 0; both_cnt = 0;
    idle_gap = 0; ack_cyc = -1; wr_cyc = -1; stray_err = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; wr_mask = '0;
    ack_log.delete(); err_log.delete();
  endtask

  // Advance one cycle, sample on the falling edge, log bus/handshake activity
  // and let requesters drop req after their ack.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (|cfg_wmask) begin wr_cnt++; wr_addr = cfg_addr; wr_data = cfg_wdata; wr_mask = cfg_wmask; wr_cyc = cyc; end
    if (|cfg_rmask) begin rd_cnt++; rd_addr = cfg_addr; end
    if ((|cfg_wmask) && (|cfg_rmask)) both_cnt++;
    if (|ack) begin
      ack_cnt++; ack_cyc = cyc; ack_log.push_back(ack); err_log.push_back(err);
      if ($countones(ack) != 1) multi_ack++;
    end
    if ((|err) && !(|ack)) stray_err++;
    if (!busy && ack_cnt >= 1 && ack_cnt < 3) idle_gap++;
    req = req & ~(ack & drop_mask);
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && ack_cnt < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    tick();
    compared += 7;
    if (ack !== '0)       begin mismatched++; $display("FAIL reset_ack got %b want 0", ack); end
    if (err !== '0)       begin mismatched++; $display("FAIL reset_err got %b want 0", err); end
    if (busy !== 1'b0)    begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    if (cfg_addr !== '0)  begin mismatched++; $display("FAIL reset_addr got %h want 0", cfg_addr); end
    if (cfg_wmask !== '0) begin mismatched++; $display("FAIL reset_wmask got %b want 0", cfg_wmask); end
    if (cfg_rmask !== '0) begin mismatched++; $display("FAIL reset_rmask got %b want 0", cfg_rmask); end
    if (cfg_wdata !== '0) begin mismatched++; $display("FAIL reset_wdata got %h want 0", cfg_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_log(); drop_mask = '1; cfg_rdata = 32'h0000_0033;
    req_sel[3 +: 3] = 3'd4; req_value[16 +: 16] = 16'h0033; req = 4'b0010;
    run_until(1, 60);
    compared += 10;
    if (ack_cnt !== 1)            begin mismatched++; $display("FAIL single_acks got %0d want 1", ack_cnt); end
    if (wr_cnt !== 1)             begin mismatched++; $display("FAIL single_writes got %0d want 1", wr_cnt); end
    if (wr_addr !== 32'h10)       begin mismatched++; $display("FAIL single_addr got %h want 10", wr_addr); end
    if (wr_mask !== 4'b0011)      begin mismatched++; $display("FAIL single_wmask got %b want 0011", wr_mask); end
    if (wr_data !== 32'h33)       begin mismatched++; $display("FAIL single_wdata got %h want 33", wr_data); end
    if (wr_cyc !== 1)             begin mismatched++; $display("FAIL single_wr_cycle got %0d want 1", wr_cyc); end
    if (ack_cyc !== 19 + RB)      begin mismatched++; $display("FAIL single_latency got %0d want %0d", ack_cyc, 19 + RB); end
    if (ack_log[0] !== 4'b0010)   begin mismatched++; $display("FAIL single_ack got %b want 0010", ack_log[0]); end
    if (err_log[0] !== 4'b0000)   begin mismatched++; $display("FAIL single_err got %b want 0000", err_log[0]); end
    if (rd_cnt !== RB / 2)        begin mismatched++; $display("FAIL single_reads got %0d want %0d", rd_cnt, RB / 2); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset(); clear_log(); drop_mask = '1;
    req_sel[0 +: 3] = 3'd0; req_value[0 +: 16]  = 16'h1111;
    req_sel[6 +: 3] = 3'd1; req_value[32 +: 16] = 16'h2222;
    req_sel[9 +: 3] = 3'd5; req_value[48 +: 16] = 16'h3333;
    req = 4'b1101;
    run_until(3, 200);
    compared += 11;
    if (ack_cnt !== 3)          begin mismatched++; $display("FAIL rr_acks got %0d want 3", ack_cnt); end
    if (ack_log[0] !== 4'b0001) begin mismatched++; $display("FAIL rr_first got %b want 0001", ack_log[0]); end
    if (ack_log[1] !== 4'b0100) begin mismatched++; $display("FAIL rr_second got %b want 0100", ack_log[1]); end
    if (ack_log[2] !== 4'b1000) begin mismatched++; $display("FAIL rr_third got %b want 1000", ack_log[2]); end
    if (multi_ack !== 0)        begin mismatched++; $display("FAIL rr_onehot got %0d want 0", multi_ack); end
    if (idle_gap !== 2)         begin mismatched++; $display("FAIL rr_idle_gap got %0d want 2", idle_gap); end
    if (wr_cnt !== 3)           begin mismatched++; $display("FAIL rr_writes got %0d want 3", wr_cnt); end
    if ((err_log[0] | err_log[1] | err_log[2]) !== 4'b0000)
                                begin mismatched++; $display("FAIL rr_err got %b want 0000", err_log[0] | err_log[1] | err_log[2]); end
    if (both_cnt !== 0)         begin mismatched++; $display("FAIL rr_masks_overlap got %0d want 0", both_cnt); end
    if (wr_data !== 32'h3333 || wr_addr !== 32'h14)
                                begin mismatched++; $display("FAIL rr_last_write got %h@%h want 3333@14", wr_data, wr_addr); end
    if (ack_cyc !== 3 * (19 + RB) + 2)
                                begin mismatched++; $display("FAIL rr_total_cycles got %0d want %0d", ack_cyc, 3 * (19 + RB) + 2); end
    tick();
  endtask

  task automatic test_invalid_sel();
    clear_log(); drop_mask = '1;
    req_sel[6 +: 3] = 3'd7; req = 4'b0100;
    run_until(1, 20);
    compared += 6;
    if (ack_cnt !== 1)          begin mismatched++; $display("FAIL inv_acks got %0d want 1", ack_cnt); end
    if (ack_cyc !== 1)          begin mismatched++; $display("FAIL inv_latency got %0d want 1", ack_cyc); end
    if (ack_log[0] !== 4'b0100) begin mismatched++; $display("FAIL inv_ack got %b want 0100", ack_log[0]); end
    if (err_log[0] !== 4'b0100) begin mismatched++; $display("FAIL inv_err got %b want 0100", err_log[0]); end
    if (wr_cnt !== 0)           begin mismatched++; $display("FAIL inv_writes got %0d want 0", wr_cnt); end
    if (rd_cnt !== 0)           begin mismatched++; $display("FAIL inv_reads got %0d want 0", rd_cnt); end
    tick();
  endtask

  task automatic test_readback();
    logic [N-1:0] exp_err;
    exp_err = (RB != 0) ? 4'b0001 : 4'b0000;
    for (int pass = 0; pass < 2; pass++) begin
      clear_log(); drop_mask = '1;
      cfg_rdata = (pass == 0) ? 32'h0000_0005 : 32'h0000_0006;
      req_sel[0 +: 3] = 3'd2; req_value[0 +: 16] = 16'h0006; req = 4'b0001;
      run_until(1, 60);
      compared += 5;
      if (ack_log[0] !== 4'b0001) begin mismatched++; $display("FAIL rb%0d_ack got %b want 0001", pass, ack_log[0]); end
      if (err_log[0] !== ((pass == 0) ? exp_err : 4'b0000))
                                  begin mismatched++; $display("FAIL rb%0d_err got %b want %b", pass, err_log[0], (pass == 0) ? exp_err : 4'b0000); end
      if (ack_cyc !== 19 + RB)    begin mismatched++; $display("FAIL rb%0d_latency got %0d want %0d", pass, ack_cyc, 19 + RB); end
      if (rd_cnt !== RB / 2)      begin mismatched++; $display("FAIL rb%0d_reads got %0d want %0d", pass, rd_cnt, RB / 2); end
      if (wr_addr !== 32'h8)      begin mismatched++; $display("FAIL rb%0d_addr got %h want 8", pass, wr_addr); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    clear_log(); drop_mask = '1;
    req_sel[3 +: 3] = 3'd1; req_value[16 +: 16] = 16'h00AA; req = 4'b0010;
    repeat (5 + RB) tick();
    compared += 1;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before got %b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    compared += 6;
    if (busy !== 1'b0)    begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
    if (ack !== '0)       begin mismatched++; $display("FAIL mid_ack got %b want 0", ack); end
    if (cfg_wmask !== '0) begin mismatched++; $display("FAIL mid_wmask got %b want 0", cfg_wmask); end
    if (cfg_rmask !== '0) begin mismatched++; $display("FAIL mid_rmask got %b want 0", cfg_rmask); end
    if (cfg_wdata !== '0 || cfg_addr !== '0)
                          begin mismatched++; $display("FAIL mid_bus got %h/%h want 0/0", cfg_wdata, cfg_addr); end
    if (ack_cnt !== 0)    begin mismatched++; $display("FAIL mid_no_ack got %0d want 0", ack_cnt); end
    req = 4'b1001;
    req_sel[0 +: 3] = 3'd0; req_value[0 +: 16]  = 16'h0101;
    req_sel[9 +: 3] = 3'd3; req_value[48 +: 16] = 16'h0303;
    tick();
    clear_log();
    rst_n = 1'b1;
    run_until(2, 100);
    compared += 3;
    if (ack_cnt !== 2)          begin mismatched++; $display("FAIL mid_acks got %0d want 2", ack_cnt); end
    if (ack_log[0] !== 4'b0001) begin mismatched++; $display("FAIL mid_first got %b want 0001", ack_log[0]); end
    if (ack_log[1] !== 4'b1000) begin mismatched++; $display("FAIL mid_second got %b want 1000", ack_log[1]); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit added;
    added = 1'b0;
    clear_log(); drop_mask = 4'b1000;
    req = 4'b0010;
    for (int k = 0; k < 200 && ack_cnt < 3; k++) begin
      tick();
      if (ack_cnt >= 1 && !added) begin req[3] = 1'b1; added = 1'b1; end
    end
    req = '0;
    compared += 5;
    if (ack_cnt !== 3)          begin mismatched++; $display("FAIL b2b_acks got %0d want 3", ack_cnt); end
    if (ack_log[0] !== 4'b0010) begin mismatched++; $display("FAIL b2b_first got %b want 0010", ack_log[0]); end
    if (ack_log[1] !== 4'b1000) begin mismatched++; $display("FAIL b2b_second got %b want 1000", ack_log[1]); end
    if (ack_log[2] !== 4'b0010) begin mismatched++; $display("FAIL b2b_third got %b want 0010", ack_log[2]); end
    if (stray_err !== 0)        begin mismatched++; $display("FAIL b2b_stray_err got %0d want 0", stray_err); end
    tick(); tick();
  endtask

  initial begin
    clear_log();
    test_reset();
    test_single();
    test_round_robin();
    test_invalid_sel();
    test_readback();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
